// File: rtl/fdc_sector_xfer.sv
// Execution-phase engine for uPD765 READ DATA / WRITE DATA: moves sectors R..EOT
// through an internal one-sector buffer between the CPU data register and the image controller.
module fdc_sector_xfer #(
  parameter int unsigned NUM_DRIVES     = 2,
  parameter int unsigned MAX_N          = 2,
  parameter int unsigned OVERRUN_CYCLES = 32768
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_start,
  input  logic                  cmd_write,
  input  logic [1:0]            cmd_drive,
  input  logic [7:0]            cmd_c,
  input  logic [7:0]            cmd_h,
  input  logic [7:0]            cmd_r,
  input  logic [7:0]            cmd_n,
  input  logic [7:0]            cmd_eot,
  input  logic                  tc,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [7:0]            cpu_din,
  output logic [7:0]            cpu_dout,
  output logic                  rqm,
  output logic                  dio,
  output logic                  exm,
  input  logic [NUM_DRIVES-1:0] drive_ready,
  input  logic [NUM_DRIVES-1:0] drive_wp,
  output logic                  disk_req,
  output logic                  disk_write,
  output logic [1:0]            disk_drive,
  output logic [23:0]           disk_chr,
  output logic [2:0]            disk_len,
  input  logic                  disk_ack,
  input  logic                  disk_err,
  input  logic [7:0]            disk_din,
  input  logic                  disk_din_valid,
  output logic [7:0]            disk_dout,
  input  logic                  disk_dout_rd,
  output logic                  done,
  output logic [7:0]            res_st0,
  output logic [7:0]            res_st1,
  output logic [7:0]            res_st2,
  output logic [7:0]            res_c,
  output logic [7:0]            res_h,
  output logic [7:0]            res_r,
  output logic [7:0]            res_n
);
  localparam int unsigned BUF_LEN = 128 << MAX_N;
  localparam int unsigned AW      = 7 + MAX_N;
  localparam int unsigned CW      = 13;
  localparam int unsigned OW      = $clog2(OVERRUN_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_TOCPU   = 3'd3;
  localparam logic [2:0] S_FROMCPU = 3'd4;
  localparam logic [2:0] S_COMMIT  = 3'd5;
  localparam logic [2:0] S_ADVANCE = 3'd6;
  localparam logic [2:0] S_FINISH  = 3'd7;

  logic [7:0]    sec_buf [BUF_LEN];
  logic [2:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d, rdptr, rdptr_d, cnt_inc, sec_len, len_mask;
  logic [OW-1:0] ovr_cnt, ovr_d;
  logic          write_q, write_d, tc_flag, tc_d;
  logic [1:0]    drv_q, drv_d;
  logic [7:0]    c_q, c_d, h_q, h_d, r_q, r_d, n_q, n_d, eot_q, eot_d;
  logic          nr, nr_d, nd, nd_d, nw, nw_d, or_f, or_d, en, en_d;
  logic          buf_we, dout_ld, done_d, rqm_d, dio_d, exm_d, req_d, ovr_hit, abnormal;
  logic [7:0]    buf_wd;
  logic [AW-1:0] cnt_addr, rd_addr;
  logic [3:0]    rdy_pad, wp_pad;

  assign rdy_pad  = 4'(drive_ready);
  assign wp_pad   = 4'(drive_wp);
  assign sec_len  = CW'(128) << n_q[2:0];
  assign len_mask = sec_len - CW'(1);
  assign cnt_inc  = cnt + CW'(1);
  assign cnt_addr = AW'(cnt & len_mask);
  assign rd_addr  = AW'(rdptr_d & len_mask);
  assign ovr_hit  = (ovr_cnt == OW'(OVERRUN_CYCLES - 1));
  assign abnormal = nr | nd | nw | or_f | en;

  // Next-state and next-output logic
  always_comb begin
    state_d = state;   cnt_d = cnt;     rdptr_d = rdptr; ovr_d = ovr_cnt;
    write_d = write_q; drv_d = drv_q;   c_d = c_q;       h_d = h_q;
    r_d = r_q;         n_d = n_q;       eot_d = eot_q;   tc_d = tc_flag;
    nr_d = nr;         nd_d = nd;       nw_d = nw;       or_d = or_f;   en_d = en;
    buf_we = 1'b0;     buf_wd = 8'h00;  dout_ld = 1'b0;  done_d = 1'b0;
    case (state)
      S_IDLE: if (cmd_start) begin
        write_d = cmd_write; drv_d = cmd_drive; c_d = cmd_c; h_d = cmd_h;
        r_d = cmd_r; n_d = cmd_n; eot_d = cmd_eot;
        cnt_d = '0; tc_d = 1'b0;
        nr_d = 1'b0; nd_d = 1'b0; nw_d = 1'b0; or_d = 1'b0; en_d = 1'b0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        ovr_d = '0;
        if (32'(drv_q) >= NUM_DRIVES || !rdy_pad[drv_q]) begin
          nr_d = 1'b1; state_d = S_FINISH;
        end else if (32'(n_q) > MAX_N) begin
          nd_d = 1'b1; state_d = S_FINISH;
        end else if (write_q && wp_pad[drv_q]) begin
          nw_d = 1'b1; state_d = S_FINISH;
        end else begin
          state_d = write_q ? S_FROMCPU : S_FETCH;
        end
      end
      S_FETCH: begin
        if (disk_din_valid && cnt < sec_len) begin
          buf_we = 1'b1; buf_wd = disk_din; cnt_d = cnt_inc;
        end
        if (disk_ack) begin
          if (disk_err) begin
            nd_d = 1'b1; state_d = S_FINISH;
          end else begin
            cnt_d = '0; ovr_d = '0; state_d = S_TOCPU;
          end
        end
      end
      S_TOCPU: begin
        if (rqm && cpu_rd) begin
          dout_ld = 1'b1; cnt_d = cnt_inc; ovr_d = '0;
          if (tc) tc_d = 1'b1;
          if (tc || cnt_inc == sec_len) state_d = S_ADVANCE;
        end else if (tc) begin
          tc_d = 1'b1; state_d = S_ADVANCE;
        end else if (ovr_hit) begin
          or_d = 1'b1; state_d = S_FINISH;
        end else begin
          ovr_d = ovr_cnt + OW'(1);
        end
      end
      S_FROMCPU: begin
        // With the TC flag set the remainder of the sector is zero-filled
        if (tc_flag) begin
          buf_we = 1'b1; cnt_d = cnt_inc;
          if (cnt_inc == sec_len) begin rdptr_d = '0; state_d = S_COMMIT; end
        end else if (rqm && cpu_wr) begin
          buf_we = 1'b1; buf_wd = cpu_din; cnt_d = cnt_inc; ovr_d = '0;
          if (tc) tc_d = 1'b1;
          if (cnt_inc == sec_len) begin rdptr_d = '0; state_d = S_COMMIT; end
        end else if (tc) begin
          tc_d = 1'b1;
        end else if (ovr_hit) begin
          or_d = 1'b1; state_d = S_FINISH;
        end else begin
          ovr_d = ovr_cnt + OW'(1);
        end
      end
      S_COMMIT: begin
        if (disk_dout_rd) rdptr_d = rdptr + CW'(1);
        if (disk_ack) begin
          if (disk_err) begin nd_d = 1'b1; state_d = S_FINISH; end
          else state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if (tc_flag) begin
          r_d = r_q + 8'd1; state_d = S_FINISH;
        end else if (r_q == eot_q) begin
          en_d = 1'b1; c_d = c_q + 8'd1; r_d = 8'd1; state_d = S_FINISH;
        end else begin
          r_d = r_q + 8'd1; cnt_d = '0; ovr_d = '0;
          state_d = write_q ? S_FROMCPU : S_FETCH;
        end
      end
      S_FINISH: begin
        done_d = 1'b1; state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rqm_d = (state_d == S_TOCPU) || (state_d == S_FROMCPU && !tc_d);
    dio_d = (state_d == S_TOCPU);
    exm_d = (state_d != S_IDLE);
    req_d = (state_d == S_FETCH) || (state_d == S_COMMIT);
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE; cnt <= '0; rdptr <= '0; ovr_cnt <= '0;
      write_q <= 1'b0; drv_q <= '0; c_q <= '0; h_q <= '0; r_q <= '0; n_q <= '0; eot_q <= '0;
      tc_flag <= 1'b0; nr <= 1'b0; nd <= 1'b0; nw <= 1'b0; or_f <= 1'b0; en <= 1'b0;
      rqm <= 1'b0; dio <= 1'b0; exm <= 1'b0; disk_req <= 1'b0; done <= 1'b0;
      disk_write <= 1'b0; disk_drive <= '0; disk_chr <= '0; disk_len <= '0;
      res_st0 <= '0; res_st1 <= '0; res_st2 <= '0;
      res_c <= '0; res_h <= '0; res_r <= '0; res_n <= '0;
    end else begin
      state <= state_d; cnt <= cnt_d; rdptr <= rdptr_d; ovr_cnt <= ovr_d;
      write_q <= write_d; drv_q <= drv_d; c_q <= c_d; h_q <= h_d; r_q <= r_d;
      n_q <= n_d; eot_q <= eot_d; tc_flag <= tc_d;
      nr <= nr_d; nd <= nd_d; nw <= nw_d; or_f <= or_d; en <= en_d;
      rqm <= rqm_d; dio <= dio_d; exm <= exm_d; disk_req <= req_d; done <= done_d;
      if (req_d) begin
        disk_write <= write_q; disk_drive <= drv_q;
        disk_chr <= {c_d, h_q, r_d}; disk_len <= n_q[2:0];
      end
      if (done_d) begin
        res_st0 <= {1'b0, abnormal, 2'b00, nr, h_q[0], drv_q};
        res_st1 <= {en, 2'b00, or_f, 1'b0, nd, nw, nd};
        res_st2 <= {7'b0, nd};
        res_c <= c_q; res_h <= h_q; res_r <= r_q; res_n <= n_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) sec_buf[cnt_addr] <= buf_wd;
  end

  // Data-path read ports
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_dout <= 8'hFF; disk_dout <= '0;
    end else begin
      if (dout_ld) cpu_dout <= sec_buf[cnt_addr];
      disk_dout <= sec_buf[rd_addr];
    end
  end
endmodule

// File: tb/tb_fdc_sector_xfer.sv
// Directed-random bench for fdc_sector_xfer: an image-controller model streams/captures
// sector bytes, and expected results are derived from the command parameters.
module tb_fdc_sector_xfer;
  localparam int unsigned NDRV = 2;
  localparam int unsigned MAXN = 2;
  localparam int unsigned OVR  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cmd_start, cmd_write, tc, cpu_rd, cpu_wr;
  logic [1:0] cmd_drive, disk_drive;
  logic [7:0] cmd_c, cmd_h, cmd_r, cmd_n, cmd_eot, cpu_din, cpu_dout;
  logic rqm, dio, exm, disk_req, disk_write, disk_ack, disk_err, disk_din_valid, disk_dout_rd, done;
  logic [NDRV-1:0] drive_ready, drive_wp;
  logic [23:0] disk_chr;
  logic [2:0]  disk_len;
  logic [7:0]  disk_din, disk_dout;
  logic [7:0]  res_st0, res_st1, res_st2, res_c, res_h, res_r, res_n;

  fdc_sector_xfer #(.NUM_DRIVES(NDRV), .MAX_N(MAXN), .OVERRUN_CYCLES(OVR)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_write(cmd_write),
    .cmd_drive(cmd_drive), .cmd_c(cmd_c), .cmd_h(cmd_h), .cmd_r(cmd_r), .cmd_n(cmd_n),
    .cmd_eot(cmd_eot), .tc(tc), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .rqm(rqm), .dio(dio), .exm(exm), .drive_ready(drive_ready),
    .drive_wp(drive_wp), .disk_req(disk_req), .disk_write(disk_write),
    .disk_drive(disk_drive), .disk_chr(disk_chr), .disk_len(disk_len),
    .disk_ack(disk_ack), .disk_err(disk_err), .disk_din(disk_din),
    .disk_din_valid(disk_din_valid), .disk_dout(disk_dout), .disk_dout_rd(disk_dout_rd),
    .done(done), .res_st0(res_st0), .res_st1(res_st1), .res_st2(res_st2),
    .res_c(res_c), .res_h(res_h), .res_r(res_r), .res_n(res_n)
  );

  int tests = 0;
  int fails = 0;
  int req_cnt = 0;
  int req_late = 0;
  int done_cnt = 0;
  bit err_mode = 1'b0;
  logic [7:0]  img_q [$];
  logic [7:0]  cap_q [$];
  logic [23:0] chr_q [$];
  logic        wr_q  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] st0_exp(input bit abn, input bit nrdy, input logic [7:0] h,
                                         input logic [1:0] drv);
    int v;
    v = (abn ? 64 : 0) + (nrdy ? 8 : 0) + 4 * int'(h[0]) + int'(drv);
    return 8'(v);
  endfunction

  always @(negedge clk) if (done) done_cnt++;

  // Image controller model: serves read sectors with random bytes, captures write sectors
  initial begin
    int len;
    bit aborted;
    logic [7:0] rb;
    disk_ack = 1'b0; disk_err = 1'b0; disk_din = '0; disk_din_valid = 1'b0; disk_dout_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && disk_req === 1'b1) begin
        len = 128 << disk_len;
        aborted = 1'b0;
        req_cnt++;
        chr_q.push_back(disk_chr);
        wr_q.push_back(disk_write);
        for (int i = 0; i < len; i++) begin
          if (!disk_write) begin
            rb = 8'($urandom); img_q.push_back(rb); disk_din = rb; disk_din_valid = 1'b1;
          end else begin
            cap_q.push_back(disk_dout); disk_dout_rd = 1'b1;
          end
          @(negedge clk);
          if (!rst_n) begin aborted = 1'b1; break; end
        end
        disk_din_valid = 1'b0; disk_dout_rd = 1'b0;
        if (!aborted) begin
          disk_err = err_mode; disk_ack = 1'b1;
          @(negedge clk);
          disk_ack = 1'b0; disk_err = 1'b0;
          if (disk_req) req_late++;
        end
      end
    end
  end

  task automatic start_cmd(input bit wr, input logic [1:0] drv, input logic [7:0] c,
                           input logic [7:0] h, input logic [7:0] r, input logic [7:0] n,
                           input logic [7:0] eot);
    img_q.delete(); cap_q.delete(); chr_q.delete(); wr_q.delete();
    @(negedge clk);
    cmd_write = wr; cmd_drive = drv; cmd_c = c; cmd_h = h; cmd_r = r; cmd_n = n; cmd_eot = eot;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic cpu_read(input bit t, output logic [7:0] b, output bit ok);
    int k;
    k = 0;
    while (!(rqm && dio) && k < 5000) begin @(negedge clk); k++; end
    ok = rqm && dio;
    cpu_rd = 1'b1; tc = t;
    @(negedge clk);
    cpu_rd = 1'b0; tc = 1'b0;
    b = cpu_dout;
  endtask

  task automatic cpu_write(input logic [7:0] b, input bit t, output bit ok);
    int k;
    k = 0;
    while (!(rqm && !dio) && k < 5000) begin @(negedge clk); k++; end
    ok = rqm && !dio;
    cpu_wr = 1'b1; cpu_din = b; tc = t;
    @(negedge clk);
    cpu_wr = 1'b0; tc = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cyc, output bit ok);
    cyc = 0;
    while (!done && cyc < bound) begin @(negedge clk); cyc++; end
    ok = done;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bad, tos, r0, d0, len;
    bit ok;
    logic [7:0] b, c, h, r;
    logic [1:0] drv;
    logic [7:0] wexp [$];

    rst_n = 1'b0; cmd_start = 1'b0; cmd_write = 1'b0; cmd_drive = '0;
    cmd_c = '0; cmd_h = '0; cmd_r = '0; cmd_n = '0; cmd_eot = '0;
    tc = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_din = '0;
    drive_ready = 2'b11; drive_wp = 2'b00;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_rqm", 32'(rqm), 0);
    chk("rst_exm", 32'(exm), 0);
    chk("rst_dio", 32'(dio), 0);
    chk("rst_disk_req", 32'(disk_req), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cpu_dout", 32'(cpu_dout), 32'hFF);
    chk("rst_res_st0", 32'(res_st0), 0);
    chk("rst_disk_chr", 32'(disk_chr), 0);
    rst_n = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b1; @(negedge clk); cpu_rd = 1'b0; @(negedge clk);
    chk("idle_rd_ignored", 32'(cpu_dout), 32'hFF);

    // Two-sector read to EOT
    c = 8'($urandom_range(0, 200)); h = 8'($urandom_range(0, 1)); drv = 2'($urandom_range(0, 1));
    r0 = req_cnt; bad = 0; tos = 0;
    start_cmd(1'b0, drv, c, h, 8'd1, 8'd2, 8'd2);
    chk("rd_exm", 32'(exm), 1);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 512; i++) begin
        cpu_read(1'b0, b, ok);
        if (!ok) tos++;
        if (img_q.size() == 0) bad++;
        else if (img_q.pop_front() !== b) bad++;
        if (s == 0 && i == 511) chk("rd_rqm_drop", 32'(rqm), 0);
      end
    end
    chk("rd_timeouts", 32'(tos), 0);
    chk("rd_data", 32'(bad), 0);
    wait_done(50, cyc, ok);
    chk("rd_done", 32'(ok), 1);
    chk("rd_reqs", 32'(req_cnt - r0), 2);
    chk("rd_chr1", (chr_q.size() > 1) ? 32'(chr_q[1]) : 32'hDEAD, 32'({c, h, 8'd2}));
    chk("rd_st0", 32'(res_st0), 32'(st0_exp(1'b1, 1'b0, h, drv)));
    chk("rd_st1", 32'(res_st1), 32'h80);
    chk("rd_st2", 32'(res_st2), 0);
    chk("rd_res_c", 32'(res_c), 32'(c + 8'd1));
    chk("rd_res_r", 32'(res_r), 1);
    chk("rd_res_h", 32'(res_h), 32'(h));
    chk("rd_res_n", 32'(res_n), 2);
    @(negedge clk);
    chk("rd_done_pulse", 32'(done), 0);

    // Read terminated by TC on byte 100 of sector 3
    c = 8'($urandom_range(0, 200)); h = 8'($urandom_range(0, 1)); drv = 2'($urandom_range(0, 1));
    r0 = req_cnt; bad = 0; tos = 0;
    start_cmd(1'b0, drv, c, h, 8'd3, 8'($urandom_range(0, 2)), 8'd9);
    for (int i = 0; i < 100; i++) begin
      cpu_read(i == 99, b, ok);
      if (!ok) tos++;
      if (img_q.size() == 0) bad++;
      else if (img_q.pop_front() !== b) bad++;
    end
    chk("tc_data", 32'(bad + tos), 0);
    wait_done(50, cyc, ok);
    chk("tc_done", 32'(ok), 1);
    chk("tc_reqs", 32'(req_cnt - r0), 1);
    chk("tc_st0", 32'(res_st0), 32'(st0_exp(1'b0, 1'b0, h, drv)));
    chk("tc_st1", 32'(res_st1), 0);
    chk("tc_res_r", 32'(res_r), 4);
    chk("tc_res_c", 32'(res_c), 32'(c));

    // Write N=1, TC together with the last byte
    c = 8'($urandom_range(0, 200)); h = 8'($urandom_range(0, 1)); drv = 2'($urandom_range(0, 1));
    r = 8'($urandom_range(1, 200));
    r0 = req_cnt; tos = 0; bad = 0; wexp.delete();
    start_cmd(1'b1, drv, c, h, r, 8'd1, r + 8'd3);
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom); wexp.push_back(b);
      cpu_write(b, i == 255, ok);
      if (!ok) tos++;
      if (i == 0) chk("wr_msr", 32'({rqm, dio}), 32'b10);
    end
    wait_done(1000, cyc, ok);
    chk("wr_done", 32'(ok), 1);
    chk("wr_reqs", 32'(req_cnt - r0), 1);
    chk("wr_dir", (wr_q.size() > 0) ? 32'(wr_q[0]) : 32'hDEAD, 1);
    chk("wr_chr", (chr_q.size() > 0) ? 32'(chr_q[0]) : 32'hDEAD, 32'({c, h, r}));
    if (cap_q.size() != 256) bad++;
    else for (int i = 0; i < 256; i++) if (cap_q[i] !== wexp[i]) bad++;
    chk("wr_data", 32'(bad + tos), 0);
    chk("wr_st0", 32'(res_st0), 32'(st0_exp(1'b0, 1'b0, h, drv)));
    chk("wr_st1", 32'(res_st1), 0);
    chk("wr_res_r", 32'(res_r), 32'(r + 8'd1));

    // Write N=0 with TC mid-sector: remainder is zero-filled
    h = 8'($urandom_range(0, 1)); drv = 2'($urandom_range(0, 1)); r = 8'($urandom_range(1, 200));
    r0 = req_cnt; tos = 0; bad = 0; wexp.delete();
    start_cmd(1'b1, drv, 8'd7, h, r, 8'd0, r + 8'd5);
    for (int i = 0; i < 50; i++) begin
      b = 8'($urandom); wexp.push_back(b);
      cpu_write(b, 1'b0, ok);
      if (!ok) tos++;
    end
    for (int i = 50; i < 128; i++) wexp.push_back(8'h00);
    tc = 1'b1; @(negedge clk); tc = 1'b0;
    wait_done(1000, cyc, ok);
    chk("fill_done", 32'(ok), 1);
    chk("fill_reqs", 32'(req_cnt - r0), 1);
    if (cap_q.size() != 128) bad++;
    else for (int i = 0; i < 128; i++) if (cap_q[i] !== wexp[i]) bad++;
    chk("fill_data", 32'(bad + tos), 0);
    chk("fill_st0", 32'(res_st0), 32'(st0_exp(1'b0, 1'b0, h, drv)));
    chk("fill_res_r", 32'(res_r), 32'(r + 8'd1));

    // Write-protected drive 1: done right after CHECK
    drive_wp = 2'b10; r0 = req_cnt;
    start_cmd(1'b1, 2'd1, 8'd4, 8'd0, 8'd1, 8'd2, 8'd9);
    wait_done(20, cyc, ok);
    chk("wp_done", 32'(ok), 1);
    chk("wp_latency", 32'(cyc), 2);
    chk("wp_reqs", 32'(req_cnt - r0), 0);
    chk("wp_st0", 32'(res_st0), 32'h41);
    chk("wp_st1", 32'(res_st1), 32'h02);
    drive_wp = 2'b00;

    // Drive not ready
    drive_ready = 2'b01; r0 = req_cnt;
    start_cmd(1'b0, 2'd1, 8'd4, 8'd1, 8'd1, 8'd2, 8'd9);
    wait_done(20, cyc, ok);
    chk("nr_done", 32'(ok), 1);
    chk("nr_st0", 32'(res_st0), 32'h4D);
    chk("nr_reqs", 32'(req_cnt - r0), 0);
    drive_ready = 2'b11;

    // Disk error on read ack
    h = 8'($urandom_range(0, 1)); drv = 2'($urandom_range(0, 1));
    err_mode = 1'b1; r0 = req_cnt;
    start_cmd(1'b0, drv, 8'd2, h, 8'd5, 8'd0, 8'd9);
    wait_done(1000, cyc, ok);
    err_mode = 1'b0;
    chk("err_done", 32'(ok), 1);
    chk("err_reqs", 32'(req_cnt - r0), 1);
    chk("err_st0", 32'(res_st0), 32'(st0_exp(1'b1, 1'b0, h, drv)));
    chk("err_st1", 32'(res_st1), 32'h05);
    chk("err_st2", 32'(res_st2), 32'h01);

    // Sector size above MAX_N
    r0 = req_cnt;
    start_cmd(1'b0, 2'd0, 8'd2, 8'd0, 8'd5, 8'd3, 8'd9);
    wait_done(20, cyc, ok);
    chk("n_done", 32'(ok), 1);
    chk("n_reqs", 32'(req_cnt - r0), 0);
    chk("n_st1", 32'(res_st1), 32'h05);
    chk("n_res_n", 32'(res_n), 3);

    // Overrun: CPU stalls after the first byte
    h = 8'($urandom_range(0, 1)); drv = 2'($urandom_range(0, 1));
    start_cmd(1'b0, drv, 8'd3, h, 8'd1, 8'd0, 8'd9);
    cpu_read(1'b0, b, ok);
    chk("ovr_first", (ok && img_q.size() > 0) ? 32'(img_q[0] === b) : 32'd0, 1);
    wait_done(OVR * 4, cyc, ok);
    chk("ovr_done", 32'(ok), 1);
    chk("ovr_window", 32'(cyc >= int'(OVR) && cyc <= int'(OVR) + 3), 1);
    chk("ovr_st0", 32'(res_st0), 32'(st0_exp(1'b1, 1'b0, h, drv)));
    chk("ovr_st1", 32'(res_st1), 32'h10);

    // Reset asserted mid-FETCH
    start_cmd(1'b0, 2'd0, 8'd3, 8'd0, 8'd1, 8'd2, 8'd9);
    len = 0;
    while (img_q.size() < 20 && len < 500) begin @(negedge clk); len++; end
    chk("fetch_reached", 32'(disk_req), 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_req", 32'(disk_req), 0);
    chk("rst_mid_exm", 32'(exm), 0);
    chk("rst_mid_res", 32'(res_st1), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_mid_no_done", 32'(done_cnt - d0), 0);
    chk("req_drop_after_ack", 32'(req_late), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
